// File: rtl/gemm_acc_if.sv
// Command, feedback-tensor and read-port bundle between the GEMM sequencer and its users.
// cmd_valid/cmd_ready: a command transfers on a rising edge where both are high; cmd_idx and cmd_clear are sampled only then.
interface gemm_acc_if #(
  parameter int ADDR_W   = 6,
  parameter int AT_WIDTH = 512
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_W-1:0]   cmd_idx;
  logic                cmd_clear;
  logic [AT_WIDTH-1:0] a_tensor;
  logic [AT_WIDTH-1:0] o_tensor;
  logic                done;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_idx;
  logic [AT_WIDTH-1:0] rd_data;
  logic                rd_valid;

  modport master (
    output cmd_valid, cmd_idx, cmd_clear, o_tensor, rd_en, rd_idx,
    input  cmd_ready, a_tensor, done, rd_data, rd_valid
  );

  modport slave (
    input  cmd_valid, cmd_idx, cmd_clear, o_tensor, rd_en, rd_idx,
    output cmd_ready, a_tensor, done, rd_data, rd_valid
  );
endinterface

// File: rtl/gemm_acc_unit.sv
// Accumulator buffer with a LOAD/WB read-modify-write sequence around the combinational gemm_op core,
// plus a one-cycle-latency read port for the store path.
module gemm_acc_unit #(
  parameter int ACC_WIDTH   = 32,
  parameter int INP_DEPTH   = 16,
  parameter int ACC_ENTRIES = 64,
  parameter int ADDR_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  gemm_acc_if.slave  bus,
  output logic [1:0] dbg_state
);
  localparam int AT_WIDTH = ACC_WIDTH * INP_DEPTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q;
  logic                clr_q;
  logic [AT_WIDTH-1:0] a_q;
  logic                done_q;
  logic [AT_WIDTH-1:0] rd_data_q;
  logic                rd_valid_q;
  logic                accept;
  logic                idx_ok;
  logic                rd_ok;
  logic                wb_we;

  // Storage is deliberately left out of reset.
  logic [AT_WIDTH-1:0] acc [ACC_ENTRIES];

  // Out-of-range indices only exist for non-power-of-2 entry counts.
  assign idx_ok = {1'b0, idx_q} < (ADDR_W+1)'(ACC_ENTRIES);
  assign rd_ok  = {1'b0, bus.rd_idx} < (ADDR_W+1)'(ACC_ENTRIES);
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign wb_we  = (state_q == WB) && idx_ok;

  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = LOAD;
      end
      LOAD:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      clr_q      <= 1'b0;
      a_q        <= '0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= (state_q == WB);
      rd_valid_q <= bus.rd_en;
      if (accept) begin
        idx_q <= bus.cmd_idx;
        clr_q <= bus.cmd_clear;
      end
      if (state_q == LOAD) a_q <= (clr_q || !idx_ok) ? '0 : acc[idx_q];
      // Write-first: a read colliding with the write-back sees the fresh result.
      if (bus.rd_en) begin
        if (wb_we && (bus.rd_idx == idx_q)) rd_data_q <= bus.o_tensor;
        else if (rd_ok)                     rd_data_q <= acc[bus.rd_idx];
        else                                rd_data_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wb_we) acc[idx_q] <= bus.o_tensor;
  end

  assign bus.a_tensor = a_q;
  assign bus.done     = done_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_gemm_acc_unit.sv
// Directed bench for gemm_acc_unit; a behavioural per-element adder stands in for gemm_op.
module tb_gemm_acc_unit;
  localparam int ACC_WIDTH = 32;
  localparam int INP_DEPTH = 16;
  localparam int ADDR_W    = 6;
  localparam int AT_WIDTH  = ACC_WIDTH * INP_DEPTH;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  gemm_acc_if #(.ADDR_W(ADDR_W), .AT_WIDTH(AT_WIDTH)) bus ();

  gemm_acc_unit #(
    .ACC_WIDTH(ACC_WIDTH), .INP_DEPTH(INP_DEPTH), .ACC_ENTRIES(64), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gemm_op stand-in: each element of o_tensor is a_tensor plus a per-element addend
  logic [AT_WIDTH-1:0] add_v;
  logic [AT_WIDTH-1:0] o_model;
  always_comb begin
    o_model = '0;
    for (int k = 0; k < INP_DEPTH; k++)
      o_model[k*ACC_WIDTH +: ACC_WIDTH] = bus.a_tensor[k*ACC_WIDTH +: ACC_WIDTH] + add_v[k*ACC_WIDTH +: ACC_WIDTH];
  end
  assign bus.o_tensor = o_model;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [AT_WIDTH-1:0] got, input logic [AT_WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // driver tasks; all start and end at #1 after a rising edge
  task automatic send_cmd(input logic [ADDR_W-1:0] idx, input logic clr, input logic [31:0] exp_a0);
    int waited = 0;
    while (!bus.cmd_ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    check("cmd_ready_wait", AT_WIDTH'(bus.cmd_ready), AT_WIDTH'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_idx   = idx;
    bus.cmd_clear = clr;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("load_state", AT_WIDTH'(dbg_state), AT_WIDTH'(1));
    @(posedge clk); #1;
    check("wb_a_tensor_e0", AT_WIDTH'(bus.a_tensor[31:0]), AT_WIDTH'(exp_a0));
    @(posedge clk); #1;
    check("done_pulse", AT_WIDTH'(bus.done), AT_WIDTH'(1));
  endtask

  task automatic rd(input logic [ADDR_W-1:0] idx, output logic [AT_WIDTH-1:0] data);
    bus.rd_en  = 1'b1;
    bus.rd_idx = idx;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    check("rd_valid", AT_WIDTH'(bus.rd_valid), AT_WIDTH'(1));
    data = bus.rd_data;
  endtask

  logic [AT_WIDTH-1:0] d;
  logic [AT_WIDTH-1:0] exp_v;
  logic [ADDR_W-1:0]   seq_idx [3];
  logic                seq_clr [3];
  int                  n_done;

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_idx   = '0;
    bus.cmd_clear = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_idx    = '0;
    add_v         = '0;
    add_v[31:0]   = 32'h0000_0010;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("rst_cmd_ready", AT_WIDTH'(bus.cmd_ready), AT_WIDTH'(1));
    check("rst_state", AT_WIDTH'(dbg_state), AT_WIDTH'(0));
    check("rst_a_tensor", bus.a_tensor, '0);
    check("rst_done", AT_WIDTH'(bus.done), AT_WIDTH'(0));
    check("rst_rd_valid", AT_WIDTH'(bus.rd_valid), AT_WIDTH'(0));
    check("rst_rd_data", bus.rd_data, '0);

    // 1: clear then read back
    send_cmd(6'd3, 1'b1, 32'h0);
    @(posedge clk); #1;
    check("done_one_cycle", AT_WIDTH'(bus.done), AT_WIDTH'(0));
    rd(6'd3, d);
    check("t1_rd_e0", AT_WIDTH'(d[31:0]), AT_WIDTH'(32'h10));
    @(posedge clk); #1;
    check("rd_valid_drop", AT_WIDTH'(bus.rd_valid), AT_WIDTH'(0));
    check("rd_data_hold", AT_WIDTH'(bus.rd_data[31:0]), AT_WIDTH'(32'h10));

    // 2: accumulate onto the same entry
    send_cmd(6'd3, 1'b0, 32'h10);
    rd(6'd3, d);
    check("t2_rd_e0", AT_WIDTH'(d[31:0]), AT_WIDTH'(32'h20));

    // 3: cmd_valid held high for idx 0,1,0
    seq_idx[0] = 6'd0; seq_clr[0] = 1'b1;
    seq_idx[1] = 6'd1; seq_clr[1] = 1'b1;
    seq_idx[2] = 6'd0; seq_clr[2] = 1'b0;
    n_done = 0;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.done) n_done++;
      if (c < 9) begin
        check($sformatf("t3_ready_c%0d", c), AT_WIDTH'(bus.cmd_ready), AT_WIDTH'((c % 3) == 0));
        if ((c % 3) == 0) begin
          bus.cmd_idx   = seq_idx[c/3];
          bus.cmd_clear = seq_clr[c/3];
        end
        @(posedge clk); #1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    check("t3_done_count", AT_WIDTH'(n_done), AT_WIDTH'(3));
    rd(6'd0, d);
    check("t3_idx0_e0", AT_WIDTH'(d[31:0]), AT_WIDTH'(32'h20));
    rd(6'd1, d);
    check("t3_idx1_e0", AT_WIDTH'(d[31:0]), AT_WIDTH'(32'h10));

    // 4: read collides with the write-back to the same entry
    send_cmd(6'd5, 1'b1, 32'h0);
    bus.cmd_valid = 1'b1;
    bus.cmd_idx   = 6'd5;
    bus.cmd_clear = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    bus.rd_en  = 1'b1;
    bus.rd_idx = 6'd5;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    check("t4_rd_valid", AT_WIDTH'(bus.rd_valid), AT_WIDTH'(1));
    check("t4_write_first", AT_WIDTH'(bus.rd_data[31:0]), AT_WIDTH'(32'h20));
    check("t4_done", AT_WIDTH'(bus.done), AT_WIDTH'(1));

    // 5: reset during write-back of idx 7
    add_v[31:0] = 32'h1;
    send_cmd(6'd7, 1'b1, 32'h0);
    add_v[31:0] = 32'h10;
    bus.cmd_valid = 1'b1;
    bus.cmd_idx   = 6'd7;
    bus.cmd_clear = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_in_wb", AT_WIDTH'(dbg_state), AT_WIDTH'(2));
    rst_n = 1'b0;
    #1;
    check("t5_state", AT_WIDTH'(dbg_state), AT_WIDTH'(0));
    check("t5_a_tensor", bus.a_tensor, '0);
    check("t5_rd_data", bus.rd_data, '0);
    check("t5_rd_valid", AT_WIDTH'(bus.rd_valid), AT_WIDTH'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_no_done_a", AT_WIDTH'(bus.done), AT_WIDTH'(0));
    @(posedge clk); #1;
    check("t5_no_done_b", AT_WIDTH'(bus.done), AT_WIDTH'(0));
    rd(6'd7, d);
    check("t5_entry_kept", AT_WIDTH'(d[31:0]), AT_WIDTH'(32'h1));

    // 6: wrap without saturation, full tensor stored verbatim
    add_v = '0;
    add_v[31:0]                 = 32'h7FFF_FFFF;
    add_v[AT_WIDTH-1 -: 32]     = 32'hA5A5_A5A5;
    send_cmd(6'd9, 1'b1, 32'h0);
    add_v = '0;
    add_v[31:0] = 32'h1;
    send_cmd(6'd9, 1'b0, 32'h7FFF_FFFF);
    rd(6'd9, d);
    exp_v = '0;
    exp_v[31:0]             = 32'h8000_0000;
    exp_v[AT_WIDTH-1 -: 32] = 32'hA5A5_A5A5;
    check("t6_wrap_full", d, exp_v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
